// File: rtl/camera_cfg_sequencer.sv
// rtl/camera_cfg_sequencer.sv - queued write/read/poll initiator for the camera cfg register bus
// Optional poll support is built when CAM_CFG_SEQ_POLL_EN is defined; otherwise op 10 is illegal.
module camera_cfg_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int POLL_TIMEOUT = 1024,
  parameter int POLL_GAP     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  input  logic [31:0] cmd_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [31:0] cfg_data_o,
  output logic [4:0]  cfg_addr_o,
  output logic        cfg_valid_o,
  output logic        cfg_rwn_o,
  input  logic [31:0] cfg_data_i,
  input  logic        cfg_ready_i,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;

`ifdef CAM_CFG_SEQ_POLL_EN
  localparam bit POLL_EN = 1'b1;
  localparam int TW = $clog2(POLL_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [TW-1:0] TRY_MAX  = TW'(POLL_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
`else
  localparam bit POLL_EN = 1'b0;
`endif

  // Reject parameter sets the pointer and counter logic cannot represent.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || POLL_TIMEOUT < 1 || POLL_GAP < 1) begin : g_param_check
    $error("camera_cfg_sequencer: illegal parameter set");
  end

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [31:0] data;
`ifdef CAM_CFG_SEQ_POLL_EN
    logic [31:0] mask;
`endif
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_GAP} state_t;

  state_t      state_q, state_d;
  cmd_t        fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]  cfg_addr_q, cfg_addr_d;
  logic [31:0] cfg_data_q, cfg_data_d;
  logic        cfg_rwn_q, cfg_rwn_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
`ifdef CAM_CFG_SEQ_POLL_EN
  logic          poll_q, poll_d;
  logic [31:0]   mask_q, mask_d;
  logic [TW-1:0] try_q, try_d;
  logic [GW-1:0] gap_q, gap_d;
`else
  logic unused_mask;
  assign unused_mask = ^cmd_mask_i;
`endif

  logic fifo_empty, fifo_full, push, head_legal;
  cmd_t push_cmd, head_cmd;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = cmd_valid_i && !fifo_full;
  assign head_cmd   = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign head_legal = (head_cmd.op == OP_WR) || (head_cmd.op == OP_RD) ||
                      (POLL_EN && head_cmd.op == OP_POLL);

  // Pack the incoming command into one FIFO word.
  always_comb begin
    push_cmd      = '0;
    push_cmd.op   = cmd_op_i;
    push_cmd.addr = cmd_addr_i;
    push_cmd.data = cmd_data_i;
`ifdef CAM_CFG_SEQ_POLL_EN
    push_cmd.mask = cmd_mask_i;
`endif
  end

  // Command storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_cmd;
    end
  end

  // Next-state logic: FIFO pointers, bus sequencing and response capture.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    cfg_rwn_d  = cfg_rwn_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef CAM_CFG_SEQ_POLL_EN
    poll_d     = poll_q;
    mask_d     = mask_q;
    try_d      = try_q;
    gap_d      = gap_q;
`endif
    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          rd_ptr_d = rd_ptr_q + (AW+1)'(1);
          if (head_legal) begin
            cfg_addr_d = head_cmd.addr;
            cfg_data_d = head_cmd.data;
            cfg_rwn_d  = (head_cmd.op != OP_WR);
`ifdef CAM_CFG_SEQ_POLL_EN
            poll_d     = (head_cmd.op == OP_POLL);
            mask_d     = head_cmd.mask;
            try_d      = '0;
`endif
            state_d    = S_ISSUE;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        if (cfg_ready_i) begin
`ifdef CAM_CFG_SEQ_POLL_EN
          if (poll_q) begin
            try_d      = try_q + TW'(1);
            rsp_data_d = cfg_data_i;
            if (((cfg_data_i ^ cfg_data_q) & mask_q) == '0) begin
              rsp_err_d = 1'b0;
              state_d   = S_RESP;
            end else if (try_d == TRY_MAX) begin
              rsp_err_d = 1'b1;
              state_d   = S_RESP;
            end else begin
              gap_d   = '0;
              state_d = S_GAP;
            end
          end else
`endif
          if (cfg_rwn_q) begin
            rsp_data_d = cfg_data_i;
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
`ifdef CAM_CFG_SEQ_POLL_EN
        if (gap_q == GAP_LAST) begin
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset also drops any pending request or response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      cfg_rwn_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef CAM_CFG_SEQ_POLL_EN
      poll_q     <= 1'b0;
      mask_q     <= '0;
      try_q      <= '0;
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      cfg_rwn_q  <= cfg_rwn_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef CAM_CFG_SEQ_POLL_EN
      poll_q     <= poll_d;
      mask_q     <= mask_d;
      try_q      <= try_d;
      gap_q      <= gap_d;
`endif
    end
  end

  assign cmd_ready_o = !fifo_full;
  assign cfg_valid_o = (state_q == S_ISSUE);
  assign cfg_addr_o  = cfg_addr_q;
  assign cfg_data_o  = cfg_data_q;
  assign cfg_rwn_o   = cfg_rwn_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_camera_cfg_sequencer.sv
// tb/tb_camera_cfg_sequencer.sv - randomized and directed bench for camera_cfg_sequencer
module tb_camera_cfg_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 4;
  localparam int GAP   = 4;
`ifdef CAM_CFG_SEQ_POLL_EN
  localparam bit POLL_EN = 1'b1;
`else
  localparam bit POLL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data, cmd_mask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic [4:0]  cfg_addr;
  logic        cfg_valid, cfg_rwn, cfg_ready, busy;

  always #5 clk = ~clk;

  camera_cfg_sequencer #(.FIFO_DEPTH(DEPTH), .POLL_TIMEOUT(TMO), .POLL_GAP(GAP)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .cfg_data_o(cfg_wdata), .cfg_addr_o(cfg_addr), .cfg_valid_o(cfg_valid), .cfg_rwn_o(cfg_rwn),
    .cfg_data_i(cfg_rdata), .cfg_ready_i(cfg_ready), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // Transaction-level reference: pending command list plus the job in progress.
  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
  } cmd_t;

  cmd_t        pend[$];
  cmd_t        cur;
  cmd_t        incoming;
  bit          bus_req  = 1'b0;
  bit          rsp_pend = 1'b0;
  int          gap_left = 0;
  int          tries    = 0;
  logic [4:0]  e_addr   = '0;
  logic [31:0] e_wdata  = '0;
  logic        e_rwn    = 1'b0;
  logic [31:0] e_rdata  = '0;
  logic        e_err    = 1'b0;
  bit          checking = 1'b0;

  function automatic bit legal(input logic [1:0] op);
    return (op == 2'b00) || (op == 2'b01) || (POLL_EN && op == 2'b10);
  endfunction

  // Advance the reference across the coming clock edge using the inputs now applied.
  task automatic model_step();
    bit acc;
    if (rst) begin
      pend.delete();
      bus_req = 0; rsp_pend = 0; gap_left = 0; tries = 0;
      e_addr = '0; e_wdata = '0; e_rwn = 0; e_rdata = '0; e_err = 0;
      return;
    end
    acc = cmd_valid && (pend.size() < DEPTH);
    if (bus_req) begin
      if (cfg_ready) begin
        bus_req = 0;
        if (cur.op == 2'b01) begin
          e_rdata = cfg_rdata; e_err = 0; rsp_pend = 1;
        end else if (cur.op == 2'b10) begin
          tries++;
          e_rdata = cfg_rdata;
          if (((cfg_rdata ^ cur.data) & cur.mask) == 32'h0) begin
            e_err = 0; rsp_pend = 1;
          end else if (tries == TMO) begin
            e_err = 1; rsp_pend = 1;
          end else begin
            gap_left = GAP;
          end
        end
      end
    end else if (gap_left > 0) begin
      gap_left--;
      if (gap_left == 0) bus_req = 1;
    end else if (rsp_pend) begin
      if (rsp_ready) rsp_pend = 0;
    end else if (pend.size() > 0) begin
      cur = pend.pop_front();
      if (legal(cur.op)) begin
        bus_req = 1; tries = 0;
        e_addr = cur.addr; e_wdata = cur.data; e_rwn = (cur.op != 2'b00);
      end else begin
        e_rdata = '0; e_err = 1; rsp_pend = 1;
      end
    end
    if (acc) begin
      incoming.op = cmd_op; incoming.addr = cmd_addr;
      incoming.data = cmd_data; incoming.mask = cmd_mask;
      pend.push_back(incoming);
    end
  endtask

  // Compare every DUT output with the reference one time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("cmd_ready", cmd_ready, pend.size() < DEPTH);
      chk("busy", busy, (pend.size() != 0) || bus_req || rsp_pend || (gap_left != 0));
      chk("cfg_valid", cfg_valid, bus_req);
      chk("rsp_valid", rsp_valid, rsp_pend);
      if (bus_req) begin
        chk("cfg_addr", cfg_addr, e_addr);
        chk("cfg_wdata", cfg_wdata, e_wdata);
        chk("cfg_rwn", cfg_rwn, e_rwn);
      end
      if (rsp_pend) begin
        chk("rsp_data", rsp_data, e_rdata);
        chk("rsp_err", rsp_err, e_err);
      end
    end
  end

  task automatic step();
    model_step();
    checking = 1'b1;
    @(negedge clk);
  endtask

  task automatic put(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d, input logic [31:0] m);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
  endtask

  int acc_cnt;
  int reads;
  int r;

  initial begin
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_mask = 0;
    rsp_ready = 0; cfg_ready = 0; cfg_rdata = 0;
    @(negedge clk);
    step(); step();
    rst = 0;
    chk("rst cmd_ready", cmd_ready, 1); chk("rst cfg_valid", cfg_valid, 0);
    chk("rst rsp_valid", rsp_valid, 0); chk("rst busy", busy, 0);
    chk("rst rsp_data", rsp_data, 0);   chk("rst rsp_err", rsp_err, 0);
    chk("rst cfg_addr", cfg_addr, 0);   chk("rst cfg_wdata", cfg_wdata, 0);

    // Single write: bus request two cycles after the handshake, one cycle long.
    cfg_ready = 1;
    put(2'b00, 5'h08, 32'h1234_5678, 32'h0); step();
    cmd_valid = 0; step();
    chk("wr valid N+2", cfg_valid, 1); chk("wr addr", cfg_addr, 5'h08);
    chk("wr data", cfg_wdata, 32'h1234_5678); chk("wr rwn", cfg_rwn, 0);
    step();
    chk("wr valid N+3", cfg_valid, 0); chk("wr no rsp", rsp_valid, 0);

    // Read with target stalling three cycles.
    cfg_ready = 0;
    put(2'b01, 5'h0B, 32'h0, 32'h0); step();
    cmd_valid = 0; step();
    for (int i = 0; i < 3; i++) begin
      chk("rd held valid", cfg_valid, 1); chk("rd held addr", cfg_addr, 5'h0B); chk("rd rwn", cfg_rwn, 1);
      step();
    end
    chk("rd valid 4th", cfg_valid, 1);
    cfg_ready = 1; cfg_rdata = 32'h00F0_0140; step();
    cfg_ready = 0;
    chk("rd valid drop", cfg_valid, 0); chk("rd rsp valid", rsp_valid, 1);
    chk("rd rsp data", rsp_data, 32'h00F0_0140); chk("rd rsp err", rsp_err, 0);
    rsp_ready = 1; step(); rsp_ready = 0;
    chk("rd rsp done", rsp_valid, 0);

    // Illegal op 11.
    put(2'b11, 5'h05, 32'hDEAD_BEEF, 32'h0); step();
    cmd_valid = 0; step();
    chk("ill rsp valid", rsp_valid, 1); chk("ill data", rsp_data, 0);
    chk("ill err", rsp_err, 1); chk("ill no bus", cfg_valid, 0);
    rsp_ready = 1; step(); rsp_ready = 0;

`ifdef CAM_CFG_SEQ_POLL_EN
    // Poll matching on the third read.
    reads = 0; cfg_ready = 1;
    put(2'b10, 5'h08, 32'h8000_0000, 32'h8000_0000); step();
    cmd_valid = 0;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      cfg_rdata = (reads == 2) ? 32'h8000_0000 : 32'h0;
      if (cfg_valid) reads++;
      step();
    end
    chk("poll rsp", rsp_valid, 1); chk("poll reads", reads, 3);
    chk("poll data", rsp_data, 32'h8000_0000); chk("poll err", rsp_err, 0);
    rsp_ready = 1; step(); rsp_ready = 0;
    // Poll that never matches.
    reads = 0;
    put(2'b10, 5'h09, 32'hA5A5_A5A5, 32'hFFFF_FFFF); step();
    cmd_valid = 0;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      cfg_rdata = 32'(reads);
      if (cfg_valid) reads++;
      step();
    end
    chk("tmo rsp", rsp_valid, 1); chk("tmo reads", reads, TMO);
    chk("tmo data", rsp_data, 32'(TMO - 1)); chk("tmo err", rsp_err, 1);
    rsp_ready = 1; step(); rsp_ready = 0;
`else
    // Without poll support op 10 behaves as illegal.
    put(2'b10, 5'h08, 32'h8000_0000, 32'h8000_0000); step();
    cmd_valid = 0; step();
    chk("op10 rsp valid", rsp_valid, 1); chk("op10 data", rsp_data, 0);
    chk("op10 err", rsp_err, 1); chk("op10 no bus", cfg_valid, 0);
    rsp_ready = 1; step(); rsp_ready = 0;
`endif

    // FIFO fill while a response is parked: no pops, so four accepts then full.
    cfg_ready = 1; cfg_rdata = 32'h0000_0055;
    put(2'b01, 5'h01, 32'h0, 32'h0); step();
    cmd_valid = 0; step(); step(); step();
    chk("fill rsp parked", rsp_valid, 1);
    cfg_ready = 0; acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      put(2'b00, 5'(i + 16), 32'h100 + 32'(i), 32'h0);
      if (cmd_ready) acc_cnt++;
      step();
    end
    cmd_valid = 0;
    chk("fill accepts", acc_cnt, DEPTH); chk("fill ready low", cmd_ready, 0);
    rsp_ready = 1; step(); rsp_ready = 0;
    chk("fill still full", cmd_ready, 0);
    step();
    chk("fill ready after pop", cmd_ready, 1);
    cfg_ready = 1;
    repeat (12) step();
    chk("fill drained", busy, 0);

    // Reset during a bus request with more commands queued.
    cfg_ready = 0;
    put(2'b00, 5'h02, 32'h2, 32'h0); step();
    put(2'b00, 5'h03, 32'h3, 32'h0); step();
    cmd_valid = 0; step();
    chk("pre-rst valid", cfg_valid, 1);
    rst = 1; step(); rst = 0;
    chk("rst1 cfg_valid", cfg_valid, 0); chk("rst1 rsp_valid", rsp_valid, 0);
    chk("rst1 busy", busy, 0); chk("rst1 cmd_ready", cmd_ready, 1);

    // Reset with a response pending.
    cfg_ready = 1;
    put(2'b01, 5'h04, 32'h0, 32'h0); step();
    cmd_valid = 0; step(); step();
    chk("pre-rst rsp", rsp_valid, 1);
    rst = 1; step(); rst = 0;
    chk("rst2 rsp_valid", rsp_valid, 0); chk("rst2 busy", busy, 0);

    // Randomized traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 399) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      r         = int'($urandom_range(0, 9));
      cmd_op    = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      cmd_addr  = 5'($urandom);
      cmd_data  = $urandom;
      r         = int'($urandom_range(0, 3));
      cmd_mask  = (r == 0) ? 32'h0 : (r == 3) ? $urandom : (32'h1 << $urandom_range(0, 31));
      cfg_ready = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 1) == 1);
      cfg_rdata = $urandom;
      step();
    end
    rst = 0; cmd_valid = 0; cfg_ready = 1; rsp_ready = 1;
    repeat (60) step();
    chk("final idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
